irq_ctl: RTL and testbench

Interrupt controller sitting directly upstream of the 65C02 core. It collects up to `NSRC` peripheral interrupt sources, synchronises them, and latches them as level or edge events. It masks them and drives the core's `IRQ` input. An optional NMI path edge-detects a dedicated source, drives the core's `NMI` input and self-acknowledges when the core fetches the NMI vector. A small 4-register window, memory-mapped by the system decoder, lets software inspect and clear state.

---
 rtl/irq_ctl.sv | 105 ++++++++++
 tb/tb_irq_ctl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctl.sv
// Maskable interrupt controller with level/edge latching and a 4-register window.
// Define IRQ_CTL_NMI_EN to build the edge-triggered NMI path with vector-fetch acknowledge.
module irq_ctl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            RST,
  input  logic [NSRC-1:0] src,
  input  logic            nmi_src,
  input  logic [15:0]     AB,
  input  logic            WE,
  input  logic            cs,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata,
  output logic            IRQ,
  output logic            NMI
);

  logic [NSRC-1:0] s1, s2, s3;
  logic [NSRC-1:0] pend, mask, edg;
  logic [NSRC-1:0] rise, clr, pm, pend_n;
  logic [7:0]      vec;
  logic            wr;

  assign wr   = cs & we;
  assign rise = s2 & ~s3;
  assign clr  = (wr && addr == 2'd0) ? wdata[NSRC-1:0] : '0;
  assign pm   = pend & mask;

  // Level bits track the line; edge bits latch, and a new event beats a W1C
  assign pend_n = (~edg & s2) | (edg & (rise | (pend & ~clr)));

  always_comb begin
    vec = 8'h80;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pm[i]) vec = {5'd0, 3'(i)};
    end
  end

  function automatic logic [7:0] ext(input logic [NSRC-1:0] v);
    logic [7:0] r;
    r = '0;
    r[NSRC-1:0] = v;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (RST) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      pend  <= '0;
      mask  <= '0;
      edg   <= '0;
      rdata <= 8'h00;
      IRQ   <= 1'b0;
    end else begin
      s1   <= src;
      s2   <= s1;
      s3   <= s2;
      pend <= pend_n;
      IRQ  <= |pm;
      if (wr && addr == 2'd1) mask <= wdata[NSRC-1:0];
      if (wr && addr == 2'd2) edg  <= wdata[NSRC-1:0];
      if (cs && !we) begin
        unique case (addr)
          2'd0: rdata <= ext(pend);
          2'd1: rdata <= ext(mask);
          2'd2: rdata <= ext(edg);
          2'd3: rdata <= vec;
        endcase
      end
    end
  end

`ifdef IRQ_CTL_NMI_EN
  logic n1, n2, n3, nmi_pend, ack;

  assign ack = (AB == 16'hFFFA) && !WE;
  assign NMI = nmi_pend;

  always_ff @(posedge clk) begin
    if (RST) begin
      n1       <= 1'b0;
      n2       <= 1'b0;
      n3       <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      n1 <= nmi_src;
      n2 <= n1;
      n3 <= n2;
      if (n2 && !n3)  nmi_pend <= 1'b1;
      else if (ack)   nmi_pend <= 1'b0;
    end
  end
`else
  logic unused_nmi;

  assign unused_nmi = ^{nmi_src, AB, WE};
  assign NMI = 1'b0;
`endif

endmodule

// File: tb/tb_irq_ctl.sv
// Directed self-checking bench for irq_ctl.
// Covers reset, level/edge latching, W1C race, priority, reset mid-run and NMI.
module tb_irq_ctl;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  src = 8'h00;
  logic        nmi_src = 1'b0;
  logic [15:0] AB = 16'h0000;
  logic        WE = 1'b0;
  logic        cs = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        IRQ;
  logic        NMI;

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctl #(.NSRC(8)) dut (
    .clk(clk), .RST(RST), .src(src), .nmi_src(nmi_src),
    .AB(AB), .WE(WE), .cs(cs), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .IRQ(IRQ), .NMI(NMI)
  );

  always #5 clk = ~clk;

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic [7:0] exp_r [4];
    exp_r[0] = 8'h00; exp_r[1] = 8'h00;
    exp_r[2] = 8'h00; exp_r[3] = 8'h80;
    RST = 1'b1; src = 8'hFF;
    wait_n(2);
    n_cmp++;
    if (IRQ !== 1'b0 || NMI !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out IRQ=%b NMI=%b want 0 0", IRQ, NMI);
    end
    RST = 1'b0; src = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), d);
      n_cmp++;
      if (d !== exp_r[i]) begin
        n_bad++;
        $display("FAIL reset_reg%0d got %h want %h", i, d, exp_r[i]);
      end
    end
  endtask

  task automatic test_level;
    logic [7:0] d;
    wr_reg(2'd1, 8'h04);
    @(negedge clk);
    src = 8'h04;
    wait_n(3);
    n_cmp++;
    if (IRQ !== 1'b0) begin
      n_bad++;
      $display("FAIL level_early IRQ=%b want 0", IRQ);
    end
    wait_n(1);
    n_cmp++;
    if (IRQ !== 1'b1) begin
      n_bad++;
      $display("FAIL level_assert IRQ=%b want 1", IRQ);
    end
    rd_reg(2'd3, d);
    n_cmp++;
    if (d !== 8'h02) begin
      n_bad++;
      $display("FAIL level_vec got %h want 02", d);
    end
    @(negedge clk);
    src = 8'h00;
    wait_n(3);
    n_cmp++;
    if (IRQ !== 1'b1) begin
      n_bad++;
      $display("FAIL level_hold IRQ=%b want 1", IRQ);
    end
    wait_n(1);
    n_cmp++;
    if (IRQ !== 1'b0) begin
      n_bad++;
      $display("FAIL level_deassert IRQ=%b want 0", IRQ);
    end
    wr_reg(2'd1, 8'h00);
  endtask

  task automatic test_edge_w1c;
    logic [7:0] d;
    wr_reg(2'd2, 8'h01);
    wr_reg(2'd1, 8'h01);
    @(negedge clk); src = 8'h01;
    @(negedge clk); src = 8'h00;
    wait_n(6);
    rd_reg(2'd0, d);
    n_cmp++;
    if (d !== 8'h01 || IRQ !== 1'b1) begin
      n_bad++;
      $display("FAIL edge_latch pend=%h IRQ=%b want 01 1", d, IRQ);
    end
    // second edge detected at the same posedge that samples the W1C
    @(negedge clk); src = 8'h01;
    @(negedge clk); src = 8'h00;
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 2'd0; wdata = 8'h01;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    rd_reg(2'd0, d);
    n_cmp++;
    if (d !== 8'h01) begin
      n_bad++;
      $display("FAIL edge_race pend=%h want 01", d);
    end
    wr_reg(2'd0, 8'h01);
    n_cmp++;
    if (IRQ !== 1'b1) begin
      n_bad++;
      $display("FAIL w1c_irq_same IRQ=%b want 1", IRQ);
    end
    @(negedge clk);
    n_cmp++;
    if (IRQ !== 1'b0) begin
      n_bad++;
      $display("FAIL w1c_irq_drop IRQ=%b want 0", IRQ);
    end
    rd_reg(2'd0, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL w1c_pend got %h want 00", d);
    end
    wr_reg(2'd2, 8'h00);
  endtask

  task automatic test_priority;
    logic [7:0] d;
    wr_reg(2'd1, 8'hF0);
    src = 8'h30;
    wait_n(5);
    rd_reg(2'd3, d);
    n_cmp++;
    if (d !== 8'h04) begin
      n_bad++;
      $display("FAIL prio_vec30 got %h want 04", d);
    end
    src = 8'h20;
    wait_n(5);
    rd_reg(2'd3, d);
    n_cmp++;
    if (d !== 8'h05 || IRQ !== 1'b1) begin
      n_bad++;
      $display("FAIL prio_vec20 got %h IRQ=%b want 05 1", d, IRQ);
    end
    wr_reg(2'd1, 8'h0F);
    @(negedge clk);
    rd_reg(2'd3, d);
    n_cmp++;
    if (d !== 8'h80 || IRQ !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_masked vec=%h IRQ=%b want 80 0", d, IRQ);
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] d;
    wr_reg(2'd1, 8'h20);
    wait_n(2);
    n_cmp++;
    if (IRQ !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre IRQ=%b want 1", IRQ);
    end
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    n_cmp++;
    if (IRQ !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_irq IRQ=%b want 0", IRQ);
    end
    rd_reg(2'd1, d);
    n_cmp++;
    if (d !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst_mask got %h want 00", d);
    end
    src = 8'h00;
    wait_n(4);
  endtask

`ifdef IRQ_CTL_NMI_EN
  task automatic test_nmi;
    @(negedge clk); nmi_src = 1'b1;
    wait_n(2);
    n_cmp++;
    if (NMI !== 1'b0) begin
      n_bad++;
      $display("FAIL nmi_early NMI=%b want 0", NMI);
    end
    wait_n(1);
    n_cmp++;
    if (NMI !== 1'b1) begin
      n_bad++;
      $display("FAIL nmi_assert NMI=%b want 1", NMI);
    end
    AB = 16'hFFFA; WE = 1'b0;
    @(negedge clk);
    AB = 16'h0000;
    n_cmp++;
    if (NMI !== 1'b0) begin
      n_bad++;
      $display("FAIL nmi_ack NMI=%b want 0", NMI);
    end
    wait_n(5);
    n_cmp++;
    if (NMI !== 1'b0) begin
      n_bad++;
      $display("FAIL nmi_rearm NMI=%b want 0", NMI);
    end
    nmi_src = 1'b0;
    wait_n(4);
    nmi_src = 1'b1;
    wait_n(2);
    AB = 16'hFFFA;
    @(negedge clk);
    AB = 16'h0000;
    n_cmp++;
    if (NMI !== 1'b1) begin
      n_bad++;
      $display("FAIL nmi_race NMI=%b want 1", NMI);
    end
    AB = 16'hFFFA;
    @(negedge clk);
    AB = 16'h0000;
    nmi_src = 1'b0;
  endtask
`else
  task automatic test_nmi;
    for (int i = 0; i < 8; i++) begin
      nmi_src = ~nmi_src;
      AB = (i % 2 == 0) ? 16'hFFFA : 16'h0000;
      @(negedge clk);
      n_cmp++;
      if (NMI !== 1'b0) begin
        n_bad++;
        $display("FAIL nmi_off step%0d NMI=%b want 0", i, NMI);
      end
    end
    AB = 16'h0000;
    test_level();
  endtask
`endif

  initial begin
    test_reset();
    test_level();
    test_edge_w1c();
    test_priority();
    test_mid_reset();
    test_nmi();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
